// File: rtl/vpu_fp_div_array_pkg.sv
// Shared types and constants for the VPU FP32 divide array.
package vpu_fp_div_array_pkg;

    localparam int unsigned OPERAND_WIDTH  = 32;
    localparam int unsigned FP_FLAG_W      = 4;
    localparam int unsigned FP_DIV_LATENCY = 28;

    // Bit positions inside the divide core's m_axis_result_tuser
    localparam int unsigned TUSER_UNDERFLOW   = 0;
    localparam int unsigned TUSER_OVERFLOW    = 1;
    localparam int unsigned TUSER_INVALID     = 2;
    localparam int unsigned TUSER_DIV_BY_ZERO = 3;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    function automatic fp_flags_t tuser_to_flags(input logic [3:0] tuser);
        fp_flags_t f;
        f.invalid     = tuser[TUSER_INVALID];
        f.div_by_zero = tuser[TUSER_DIV_BY_ZERO];
        f.overflow    = tuser[TUSER_OVERFLOW];
        f.underflow   = tuser[TUSER_UNDERFLOW];
        return f;
    endfunction

endpackage

// File: rtl/floating_point_div.sv
// Behavioural stand-in for the fixed-latency FP32 divide IP core.
// Subnormals are flushed to zero, round-to-nearest-even, no reset, no backpressure.
module floating_point_div
    import vpu_fp_div_array_pkg::*;
(
    input  logic        aclk,
    input  logic        s_axis_a_tvalid,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    input  logic [31:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    output logic [31:0] m_axis_result_tdata,
    output logic [3:0]  m_axis_result_tuser
);

    localparam int unsigned LAT = FP_DIV_LATENCY;

    logic               sa, sb, sign;
    logic [7:0]         ea, eb;
    logic [22:0]        fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [49:0]        num, den;
    logic [26:0]        quo;
    logic               inexact, guard, sticky, rnd;
    logic [23:0]        mant;
    logic [24:0]        mant_r;
    logic signed [10:0] exp_q;
    logic [31:0]        res;
    logic [3:0]         usr;

    logic [LAT-1:0]     vld_pipe;
    logic [31:0]        dat_pipe [LAT];
    logic [3:0]         usr_pipe [LAT];

    assign {sa, ea, fa} = s_axis_a_tdata;
    assign {sb, eb, fb} = s_axis_b_tdata;
    assign sign   = sa ^ sb;
    assign a_nan  = (ea == 8'hFF) && (fa != '0);
    assign b_nan  = (eb == 8'hFF) && (fb != '0);
    assign a_inf  = (ea == 8'hFF) && (fa == '0);
    assign b_inf  = (eb == 8'hFF) && (fb == '0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    // Quotient with 26 extra bits: enough for 24 mantissa + guard + sticky for any ratio in (0.5, 2)
    always_comb begin
        num     = {1'b1, fa, 26'b0};
        den     = {26'b0, 1'b1, fb};
        quo     = 27'(num / den);
        inexact = (num % den) != '0;
        exp_q   = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 11'sd127;
        if (quo[26]) begin
            mant   = quo[26:3];
            guard  = quo[2];
            sticky = (quo[1:0] != 2'b00) || inexact;
        end else begin
            mant   = quo[25:2];
            guard  = quo[1];
            sticky = quo[0] || inexact;
            exp_q  = exp_q - 11'sd1;
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'b0, rnd};
        if (mant_r[24]) exp_q = exp_q + 11'sd1;

        res = '0;
        usr = '0;
        if (a_nan || b_nan) begin
            res = 32'h7FC00000;
            usr[TUSER_INVALID] = (a_nan && !fa[22]) || (b_nan && !fb[22]);
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            res = 32'h7FC00000;
            usr[TUSER_INVALID] = 1'b1;
        end else if (a_inf || b_zero) begin
            res = {sign, 8'hFF, 23'b0};
            usr[TUSER_DIV_BY_ZERO] = b_zero;
        end else if (a_zero || b_inf) begin
            res = {sign, 31'b0};
        end else if (exp_q >= 11'sd255) begin
            res = {sign, 8'hFF, 23'b0};
            usr[TUSER_OVERFLOW] = 1'b1;
        end else if (exp_q <= 11'sd0) begin
            res = {sign, 31'b0};
            usr[TUSER_UNDERFLOW] = 1'b1;
        end else begin
            res = {sign, exp_q[7:0], mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
        end
    end

    // Fixed-latency pipeline, intentionally without reset like the real core
    always_ff @(posedge aclk) begin
        vld_pipe    <= {vld_pipe[LAT-2:0], s_axis_a_tvalid & s_axis_b_tvalid};
        dat_pipe[0] <= res;
        usr_pipe[0] <= usr;
        for (int unsigned k = 1; k < LAT; k++) begin
            dat_pipe[k] <= dat_pipe[k-1];
            usr_pipe[k] <= usr_pipe[k-1];
        end
    end

    assign m_axis_result_tvalid = vld_pipe[LAT-1];
    assign m_axis_result_tdata  = dat_pipe[LAT-1];
    assign m_axis_result_tuser  = usr_pipe[LAT-1];

endmodule

// File: rtl/vpu_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of 2.
module vpu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/vpu_fp_div_array.sv
// Multi-lane FP32 divide unit: handshake, lane mask, credit-buffered results, sticky flags.
module vpu_fp_div_array
    import vpu_fp_div_array_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned OPERAND_W   = OPERAND_WIDTH,
    parameter int unsigned DIV_LATENCY = FP_DIV_LATENCY,
    parameter int unsigned FIFO_DEPTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [LANES-1:0]             lane_mask_i,
    input  logic [LANES*OPERAND_W-1:0]   op_0_i,
    input  logic [LANES*OPERAND_W-1:0]   op_1_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [LANES*OPERAND_W-1:0]   result_o,
    output logic [LANES*FP_FLAG_W-1:0]   lane_flags_o,
    output logic [FP_FLAG_W-1:0]         sticky_flags_o,
    input  logic                         flags_clr_i
);

    localparam int unsigned RES_W   = LANES*OPERAND_W;
    localparam int unsigned FLG_W   = LANES*FP_FLAG_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DRAIN_W = $clog2(DIV_LATENCY + 1);

    logic                   accept, pop, fifo_wr, drain_active;
    logic [CNT_W-1:0]       credits, fifo_count;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic [LANES-1:0]       mask_dly [DIV_LATENCY];
    logic [LANES-1:0]       core_valid;
    logic [OPERAND_W-1:0]   core_data [LANES];
    logic [3:0]             core_user [LANES];
    logic [RES_W-1:0]       wr_res;
    logic [FLG_W-1:0]       wr_flg;
    logic [FLG_W+RES_W-1:0] fifo_rd;
    logic                   fifo_empty, fifo_full;
    logic [FP_FLAG_W-1:0]   head_or;

    assign accept       = in_valid_i && in_ready_o;
    assign pop          = out_valid_o && out_ready_i;
    assign drain_active = (drain_cnt != '0);
    assign in_ready_o   = (credits != '0) && !drain_active;
    assign fifo_wr      = core_valid[0] && !drain_active;
    assign out_valid_o  = !fifo_empty;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        floating_point_div u_div (
            .aclk                 (clk),
            .s_axis_a_tvalid      (accept),
            .s_axis_a_tdata       (op_0_i[g*OPERAND_W +: OPERAND_W]),
            .s_axis_b_tvalid      (accept),
            .s_axis_b_tdata       (op_1_i[g*OPERAND_W +: OPERAND_W]),
            .m_axis_result_tvalid (core_valid[g]),
            .m_axis_result_tdata  (core_data[g]),
            .m_axis_result_tuser  (core_user[g])
        );
    end

    // Lane mask travels alongside the core pipeline so it lines up with the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DIV_LATENCY; k++) mask_dly[k] <= '0;
        end else begin
            mask_dly[0] <= lane_mask_i;
            for (int unsigned k = 1; k < DIV_LATENCY; k++) mask_dly[k] <= mask_dly[k-1];
        end
    end

    // Single credit counter covers both FIFO occupancy and in-flight vectors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               credits <= CNT_W'(FIFO_DEPTH);
        else if (accept && !pop)  credits <= credits - 1'b1;
        else if (pop && !accept)  credits <= credits + 1'b1;
    end

    // Unresettable core may still emit pre-reset results; ignore its output for one latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            drain_cnt <= DRAIN_W'(DIV_LATENCY);
        else if (drain_active) drain_cnt <= drain_cnt - 1'b1;
    end

    // Zero masked lanes before they enter the buffer
    always_comb begin
        wr_res = '0;
        wr_flg = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mask_dly[DIV_LATENCY-1][i]) begin
                wr_res[i*OPERAND_W +: OPERAND_W] = core_data[i];
                wr_flg[i*FP_FLAG_W +: FP_FLAG_W] = tuser_to_flags(core_user[i]);
            end
        end
    end

    vpu_sync_fifo #(
        .WIDTH (FLG_W + RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data ({wr_flg, wr_res}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Head entry drives the outputs; zero while empty
    always_comb begin
        result_o     = '0;
        lane_flags_o = '0;
        head_or      = '0;
        if (!fifo_empty) begin
            result_o     = fifo_rd[RES_W-1:0];
            lane_flags_o = fifo_rd[FLG_W+RES_W-1:RES_W];
        end
        for (int unsigned i = 0; i < LANES; i++) head_or = head_or | lane_flags_o[i*FP_FLAG_W +: FP_FLAG_W];
    end

    // Sticky accumulation; a clear coinciding with a handshake keeps only the new flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           sticky_flags_o <= '0;
        else if (flags_clr_i) sticky_flags_o <= pop ? head_or : '0;
        else if (pop)         sticky_flags_o <= sticky_flags_o | head_or;
    end

    assert property (@(posedge clk) disable iff (!rst_n) core_valid == {LANES{core_valid[0]}})
        else $fatal(1, "vpu_fp_div_array: lane tvalid incoherent");
    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wr && fifo_full))
        else $error("vpu_fp_div_array: result buffer overflow");
    assert property (@(posedge clk) disable iff (!rst_n)
                     ({1'b0, credits} + {1'b0, fifo_count}) <= (CNT_W+1)'(FIFO_DEPTH))
        else $error("vpu_fp_div_array: credit accounting broken");

endmodule
